// File: rtl/imem_loader_pkg.sv
// Shared helpers for the imem loader: word geometry derived from the imem word width.
package imem_loader_pkg;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/imem_loader_defs.vh
// Loader FSM encodings and word geometry; included inside the imem_loader module body.
localparam int BPW = bytes_per_word(DATA_WIDTH);

typedef enum logic [2:0] {
  IDLE   = 3'd0,
  CNT_LO = 3'd1,
  CNT_HI = 3'd2,
  DATA   = 3'd3,
  WRITE  = 3'd4,
  CSUM   = 3'd5
} state_e;

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: first byte of a word lands in word[7:0].
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int CW  = cnt_width(BPW);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last;

  assign last = (cnt_q == CW'(BPW - 1));

  // word is the value the shift register takes on this byte, so the
  // completed word is available in the same cycle as its final byte.
  generate
    if (BPW == 1) begin : g_single
      assign word = byte_in;
    end else begin : g_multi
      assign word = {byte_in, sr_q[DATA_WIDTH-1:8]};
    end
  endgenerate

  assign word_full = shift & last & ~clr;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (shift) begin
      sr_d  = word;
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (SYNC, count, data, checksum) into imem while holding the
// core in reset; releases the core only when the trailing checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] wa,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  `include "imem_loader_defs.vh"

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rdy_q, rdy_d;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [16:0]           words_q, words_d;

  logic                  accept;
  logic                  pk_clr, pk_shift, pk_full;
  logic [DATA_WIDTH-1:0] pk_word;
  logic [16:0]           n_words;

  assign accept  = in_valid & rdy_q;
  assign n_words = {1'b0, in_data, cnt_lo_q};

  imem_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .shift     (pk_shift),
    .byte_in   (in_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    hold_d   = hold_q;
    err_d    = err_q;
    sum_d    = sum_q;
    cnt_lo_d = cnt_lo_q;
    words_d  = words_q;
    done_d   = 1'b0;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = CNT_LO;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          wa_d    = '0;
          sum_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      CNT_LO: begin
        if (accept) begin
          cnt_lo_d = in_data;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          // Oversized images are rejected before anything is written.
          if (n_words > DEPTH) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (n_words == '0) begin
            state_d = CSUM;
          end else begin
            words_d = n_words;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          pk_shift = 1'b1;
          sum_d    = sum_q + in_data;
          if (pk_full) begin
            wd_d    = pk_word;
            words_d = words_q - 17'd1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // Address advances only when another word follows, so a full-depth
        // image leaves wa on the last slot instead of wrapping.
        if (words_q != '0) begin
          wa_d    = wa_q + 1'b1;
          state_d = DATA;
        end else begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == sum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wen_d = (state_d == WRITE);
    rdy_d = (state_d != WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wa_q     <= '0;
      wen_q    <= 1'b0;
      wd_q     <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b1;
      sum_q    <= '0;
      cnt_lo_q <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      wa_q     <= wa_d;
      wen_q    <= wen_d;
      wd_q     <= wd_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      sum_q    <= sum_d;
      cnt_lo_q <= cnt_lo_d;
      words_q  <= words_d;
    end
  end

  assign in_ready = rdy_q;
  assign wa       = wa_q;
  assign wen      = wen_q;
  assign wd       = wd_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle-exact vector table plus framed-load sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  wa;
  logic        wen;
  logic [15:0] wd;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int wcount = 0;
  int done_cnt = 0;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  imem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wa       (wa),
    .wen      (wen),
    .wd       (wd),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Write/done monitor; also checks in_ready is low exactly in write cycles.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wen === 1'b1) begin
        mem[wa] = wd;
        wcount++;
      end
      if (done === 1'b1) done_cnt++;
      chk("ready_vs_wen", {31'd0, in_ready}, {31'd0, ~wen});
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input logic gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      failures++;
      $display("FAIL send_timeout actual=stalled required=ready");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w[$], input logic bad, input logic gaps);
    logic [7:0] s;
    int n;
    s = 8'h00;
    n = w.size();
    send_byte(8'hA5, gaps);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    foreach (w[i]) begin
      s = s + w[i][7:0] + w[i][15:8];
      send_byte(w[i][7:0], gaps);
      send_byte(w[i][15:8], gaps);
    end
    send_byte(bad ? s + 8'h01 : s, gaps);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        wen;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic        hold;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [15:0] fr[$];
    int wc0, dc0;

    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h34, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h78, 1'b1, 1'b0, 8'h01, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h78, 1'b1, 1'b0, 8'h01, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h56, 1'b0, 1'b1, 8'h01, 16'h5678, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h14, 1'b1, 1'b0, 8'h01, 16'h5678, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h14, 1'b1, 1'b0, 8'h01, 16'h5678, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 16'h5678, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_wa", {24'd0, wa}, 32'd0);
    chk("rst_wd", {16'd0, wd}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: cycle-exact good frame
    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("t1_ready[%0d]", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      chk($sformatf("t1_wen[%0d]", i), {31'd0, wen}, {31'd0, vecs[i].wen});
      chk($sformatf("t1_wa[%0d]", i), {24'd0, wa}, {24'd0, vecs[i].wa});
      chk($sformatf("t1_wd[%0d]", i), {16'd0, wd}, {16'd0, vecs[i].wd});
      chk($sformatf("t1_hold[%0d]", i), {31'd0, cpu_hold}, {31'd0, vecs[i].hold});
      chk($sformatf("t1_done[%0d]", i), {31'd0, done}, {31'd0, vecs[i].done});
      chk($sformatf("t1_err[%0d]", i), {31'd0, err}, {31'd0, vecs[i].err});
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t1_writes", wcount, 2);
    chk("t1_mem0", {16'd0, mem[0]}, 32'h1234);
    chk("t1_mem1", {16'd0, mem[1]}, 32'h5678);

    // 2: bad checksum, then a good frame recovers
    wc0 = wcount; dc0 = done_cnt;
    mem[0] = 16'hDEAD; mem[1] = 16'hDEAD;
    fr = '{16'h1234, 16'h5678};
    send_frame(fr, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_writes", wcount - wc0, 2);
    chk("t2_mem0", {16'd0, mem[0]}, 32'h1234);
    chk("t2_mem1", {16'd0, mem[1]}, 32'h5678);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t2_nodone", done_cnt - dc0, 0);
    fr = '{16'hBEEF};
    send_frame(fr, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_err_clr", {31'd0, err}, 32'd0);
    chk("t2_release", {31'd0, cpu_hold}, 32'd0);
    chk("t2_done", done_cnt - dc0, 1);
    chk("t2_mem0b", {16'd0, mem[0]}, 32'hBEEF);

    // 3: garbage ignored, empty frame
    wc0 = wcount; dc0 = done_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    chk("t3_garbage_hold", {31'd0, cpu_hold}, 32'd0);
    fr = {};
    send_frame(fr, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_nowen", wcount - wc0, 0);
    chk("t3_done", done_cnt - dc0, 1);
    chk("t3_hold", {31'd0, cpu_hold}, 32'd0);

    // 4: oversized count, then full-depth image
    wc0 = wcount; dc0 = done_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t4_idle_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_nowen", wcount - wc0, 0);
    chk("t4_nodone", done_cnt - dc0, 0);
    fr = {};
    for (int i = 0; i < 256; i++) fr.push_back({8'(i) ^ 8'h5A, 8'(i)});
    send_frame(fr, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_full_writes", wcount - wc0, 256);
    chk("t4_full_done", done_cnt - dc0, 1);
    chk("t4_full_wa", {24'd0, wa}, 32'hFF);
    chk("t4_full_err", {31'd0, err}, 32'd0);
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== fr[i]) bad++;
      chk("t4_full_image", bad, 0);
    end

    // 5: SYNC value inside data, gapless then gapped
    fr = '{16'hA5A5, 16'h00A5, 16'h1234};
    for (int pass = 0; pass < 2; pass++) begin
      wc0 = wcount; dc0 = done_cnt;
      for (int i = 0; i < 3; i++) mem[i] = 16'hDEAD;
      send_frame(fr, 1'b0, pass == 1);
      @(negedge clk);
      chk($sformatf("t5_mem0[%0d]", pass), {16'd0, mem[0]}, 32'hA5A5);
      chk($sformatf("t5_mem1[%0d]", pass), {16'd0, mem[1]}, 32'h00A5);
      chk($sformatf("t5_mem2[%0d]", pass), {16'd0, mem[2]}, 32'h1234);
      chk($sformatf("t5_writes[%0d]", pass), wcount - wc0, 3);
      chk($sformatf("t5_done[%0d]", pass), done_cnt - dc0, 1);
    end

    // 6: reset mid-DATA
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_wen", {31'd0, wen}, 32'd0);
    chk("t6_wa", {24'd0, wa}, 32'd0);
    chk("t6_wd", {16'd0, wd}, 32'd0);
    chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wc0 = wcount; dc0 = done_cnt;
    fr = '{16'hCAFE, 16'h0102};
    send_frame(fr, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_mem0", {16'd0, mem[0]}, 32'hCAFE);
    chk("t6_mem1", {16'd0, mem[1]}, 32'h0102);
    chk("t6_done_after", done_cnt - dc0, 1);
    chk("t6_writes", wcount - wc0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
